// File: rtl/mcpu_shift_pkg.sv
// Shared definitions for the MCPU shift/rotate unit: mode codes, FSM states
// and the effective shift-count rule.
package mcpu_shift_pkg;

  // Mode encodings; codes 3'b101..3'b111 are illegal and behave as a zero count.
  localparam logic [2:0] SH_LSL = 3'b000;
  localparam logic [2:0] SH_LSR = 3'b001;
  localparam logic [2:0] SH_ASR = 3'b010;
  localparam logic [2:0] SH_ROL = 3'b011;
  localparam logic [2:0] SH_ROR = 3'b100;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Shifts saturate at the word width, rotates wrap modulo the width (a power of 2).
  // The amount is taken as 32 bits, so amount operands wider than 32 bits are not supported.
  function automatic logic [31:0] eff_count(input logic [2:0]  mode,
                                            input logic [31:0] amount,
                                            input logic [31:0] width);
    logic [31:0] n;
    n = '0;
    case (mode)
      SH_LSL, SH_LSR, SH_ASR: n = (amount > width) ? width : amount;
      SH_ROL, SH_ROR:         n = amount & (width - 32'd1);
      default:                n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mcpu_shift_step.sv
// Combinational single step of the shift unit: shifts or rotates a value by
// k positions (0..STEP) and reports the last bit that left the word.
module mcpu_shift_step
  import mcpu_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1,
  localparam int unsigned KW   = $clog2(STEP + 1),
  localparam int unsigned IW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [2:0]       i_mode,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_shifted,
  output logic             o_out_bit
);

  logic [31:0]   w_k;
  logic [31:0]   w_k_inv;
  logic [IW-1:0] w_left_idx;
  logic [IW-1:0] w_right_idx;

  assign w_k         = 32'(i_k);
  assign w_k_inv     = WIDTH - w_k;
  // Bit that leaves the top (left modes) or bottom (right modes) last.
  assign w_left_idx  = IW'(w_k_inv);
  assign w_right_idx = IW'(w_k - 32'd1);

  // Select the shifted value and the outgoing bit for the current mode.
  always_comb begin
    o_shifted = i_value;
    o_out_bit = 1'b0;
    case (i_mode)
      SH_LSL: begin
        o_shifted = i_value << w_k;
        o_out_bit = i_value[w_left_idx];
      end
      SH_LSR: begin
        o_shifted = i_value >> w_k;
        o_out_bit = i_value[w_right_idx];
      end
      SH_ASR: begin
        // MSB is preserved across steps, so it always holds the original sign.
        o_shifted = $unsigned($signed(i_value) >>> w_k);
        o_out_bit = i_value[w_right_idx];
      end
      SH_ROL: begin
        // A shift by WIDTH yields zero, so k == 0 leaves the value intact.
        o_shifted = (i_value << w_k) | (i_value >> w_k_inv);
        o_out_bit = i_value[w_left_idx];
      end
      SH_ROR: begin
        o_shifted = (i_value >> w_k) | (i_value << w_k_inv);
        o_out_bit = i_value[w_right_idx];
      end
      default: begin
        o_shifted = i_value;
        o_out_bit = 1'b0;
      end
    endcase
    if (i_k == '0) begin
      o_out_bit = 1'b0;
    end
  end

endmodule

// File: rtl/mcpu_shift_unit.sv
// Multi-cycle shift/rotate execution unit: accepts a request in IDLE, shifts
// up to STEP positions per clock in SHIFT, publishes result and flags in DONE.
module mcpu_shift_unit
  import mcpu_shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned AMT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [AMT_WIDTH-1:0] amount,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 carry_out,
  output logic                 zero
);

  localparam int unsigned REM_W = $clog2(WIDTH + 1);
  localparam int unsigned KW    = $clog2(STEP + 1);

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_work, w_work_next;
  logic [REM_W-1:0]   r_rem, w_rem_next;
  logic [2:0]         r_mode, w_mode_next;
  logic               r_carry, w_carry_next;
  logic [WIDTH-1:0]   r_result, w_result_next;
  logic               r_carry_out, w_carry_out_next;
  logic               r_zero, w_zero_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;

  logic [REM_W-1:0]   w_rem_load;
  logic [KW-1:0]      w_k;
  logic [WIDTH-1:0]   w_step_value;
  logic               w_step_bit;

  assign w_rem_load = REM_W'(eff_count(mode, 32'(amount), 32'(WIDTH)));
  // Step size is min(STEP, rem).
  assign w_k        = (r_rem >= REM_W'(STEP)) ? KW'(STEP) : KW'(r_rem);

  mcpu_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_value   (r_work),
    .i_mode    (r_mode),
    .i_k       (w_k),
    .o_shifted (w_step_value),
    .o_out_bit (w_step_bit)
  );

  // Next-state and datapath updates for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    w_state_next     = r_state;
    w_work_next      = r_work;
    w_rem_next       = r_rem;
    w_mode_next      = r_mode;
    w_carry_next     = r_carry;
    w_result_next    = r_result;
    w_carry_out_next = r_carry_out;
    w_zero_next      = r_zero;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_work_next  = data_in;
          w_rem_next   = w_rem_load;
          w_mode_next  = mode;
          w_carry_next = 1'b0;
          w_busy_next  = 1'b1;
          w_state_next = StShift;
        end
      end
      StShift: begin
        if (r_rem != '0) begin
          w_work_next  = w_step_value;
          w_rem_next   = r_rem - REM_W'(w_k);
          w_carry_next = w_step_bit;
        end else begin
          w_result_next    = r_work;
          w_carry_out_next = r_carry;
          w_zero_next      = (r_work == '0);
          w_done_next      = 1'b1;
          w_busy_next      = 1'b0;
          w_state_next     = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_work      <= '0;
      r_rem       <= '0;
      r_mode      <= SH_LSL;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_work      <= w_work_next;
      r_rem       <= w_rem_next;
      r_mode      <= w_mode_next;
      r_carry     <= w_carry_next;
      r_result    <= w_result_next;
      r_carry_out <= w_carry_out_next;
      r_zero      <= w_zero_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign zero      = r_zero;

endmodule

// File: tb/tb_mcpu_shift_unit.sv
// Bench for mcpu_shift_unit: a STEP=1 and a STEP=4 instance (WIDTH=8), driven
// with directed and random requests and checked against an arithmetic model.
module tb_mcpu_shift_unit;

  logic       clk = 1'b0;
  logic       rst_v   [2];
  logic       start_v [2];
  logic [2:0] mode_v  [2];
  logic [7:0] data_v  [2];
  logic [7:0] amt_v   [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [7:0] res_v   [2];
  logic       cy_v    [2];
  logic       zero_v  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mcpu_shift_unit #(.WIDTH(8), .STEP(1), .AMT_WIDTH(8)) u_dut_s1 (
    .clk       (clk),
    .reset     (rst_v[0]),
    .start     (start_v[0]),
    .mode      (mode_v[0]),
    .data_in   (data_v[0]),
    .amount    (amt_v[0]),
    .busy      (busy_v[0]),
    .done      (done_v[0]),
    .result    (res_v[0]),
    .carry_out (cy_v[0]),
    .zero      (zero_v[0])
  );

  mcpu_shift_unit #(.WIDTH(8), .STEP(4), .AMT_WIDTH(8)) u_dut_s4 (
    .clk       (clk),
    .reset     (rst_v[1]),
    .start     (start_v[1]),
    .mode      (mode_v[1]),
    .data_in   (data_v[1]),
    .amount    (amt_v[1]),
    .busy      (busy_v[1]),
    .done      (done_v[1]),
    .result    (res_v[1]),
    .carry_out (cy_v[1]),
    .zero      (zero_v[1])
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 8-bit shift/rotate computed from the operation's definition.
  function automatic void model(input int md, input int d, input int amt, input int stp,
                                output int res, output int cy, output int lat);
    int n;
    int sd;
    if (md <= 2)      n = (amt > 8) ? 8 : amt;
    else if (md <= 4) n = amt % 8;
    else              n = 0;
    sd = (d >= 128) ? d - 256 : d;
    case (md)
      0: begin res = (d << n) & 255; cy = (n > 0) ? (d >> (8 - n)) & 1 : 0; end
      1: begin res = d >> n;         cy = (n > 0) ? (d >> (n - 1)) & 1 : 0; end
      2: begin res = (sd >>> n) & 255; cy = (n > 0) ? (sd >>> (n - 1)) & 1 : 0; end
      3: begin res = ((d << n) | (d >> (8 - n))) & 255; cy = (n > 0) ? res & 1 : 0; end
      4: begin res = ((d >> n) | (d << (8 - n))) & 255; cy = (n > 0) ? (res >> 7) & 1 : 0; end
      default: begin res = d; cy = 0; end
    endcase
    lat = (n + stp - 1) / stp + 1;
  endfunction

  // One request: latency (edges after accept), result, flags, pulse width,
  // no acceptance in DONE, and no extra done pulse afterwards.
  task automatic run_op(input int u, input int md, input int d, input int amt,
                        input int e_res, input int e_cy, input int e_lat,
                        input bit poke, input string tag);
    int edges;
    int dones;
    @(negedge clk);
    start_v[u] = 1'b1;
    mode_v[u]  = md[2:0];
    data_v[u]  = d[7:0];
    amt_v[u]   = amt[7:0];
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    mode_v[u]  = 3'($urandom);
    data_v[u]  = 8'($urandom);
    amt_v[u]   = 8'($urandom);
    check_eq({tag, "_busy_on"}, int'(busy_v[u]), 1);
    edges = 0;
    while (!done_v[u] && edges < 40) begin
      start_v[u] = poke && (edges == 1);
      @(posedge clk); #1;
      edges++;
    end
    start_v[u] = 1'b0;
    check_eq({tag, "_latency"}, edges, e_lat);
    check_eq({tag, "_result"}, int'(res_v[u]), e_res);
    check_eq({tag, "_carry"}, int'(cy_v[u]), e_cy);
    check_eq({tag, "_zero"}, int'(zero_v[u]), (e_res == 0) ? 1 : 0);
    check_eq({tag, "_busy_off"}, int'(busy_v[u]), 0);
    start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    check_eq({tag, "_done_pulse"}, int'(done_v[u]), 0);
    check_eq({tag, "_no_accept_in_done"}, int'(busy_v[u]), 0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_v[u]) dones++;
    end
    check_eq({tag, "_extra_done"}, dones, 0);
  endtask

  task automatic run_model(input int u, input int md, input int d, input int amt,
                           input bit poke, input string tag);
    int r;
    int c;
    int l;
    model(md, d, amt, (u == 0) ? 1 : 4, r, c, l);
    run_op(u, md, d, amt, r, c, l, poke, tag);
  endtask

  initial begin
    int dones;
    for (int u = 0; u < 2; u++) begin
      rst_v[u] = 1'b1; start_v[u] = 1'b0; mode_v[u] = '0; data_v[u] = '0; amt_v[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check_eq("rst_busy", int'(busy_v[u]), 0);
      check_eq("rst_done", int'(done_v[u]), 0);
      check_eq("rst_result", int'(res_v[u]), 0);
      check_eq("rst_carry", int'(cy_v[u]), 0);
      check_eq("rst_zero", int'(zero_v[u]), 0);
    end
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    run_op(0, 0, 8'h7D, 5,  8'hA0, 1, 6, 1'b0, "lsl_7d_5");
    run_op(0, 2, 8'h80, 3,  8'hF0, 0, 4, 1'b0, "asr_80_3");
    run_op(0, 1, 8'h7D, 12, 8'h00, 0, 9, 1'b0, "lsr_7d_12");
    run_op(0, 4, 8'h81, 1,  8'hC0, 1, 2, 1'b0, "ror_81_1");
    run_op(0, 3, 8'h81, 9,  8'h03, 1, 2, 1'b0, "rol_81_9");
    run_op(0, 0, 8'h55, 0,  8'h55, 0, 1, 1'b0, "lsl_55_0");
    run_op(0, 7, 8'h3C, 4,  8'h3C, 0, 1, 1'b0, "illegal_3c");
    run_op(0, 2, 8'hA5, 200, 8'hFF, 1, 9, 1'b0, "asr_sat");
    run_op(0, 0, 8'h7D, 5,  8'hA0, 1, 6, 1'b1, "lsl_restart_ignored");
    run_op(1, 0, 8'h7D, 5,  8'hA0, 1, 3, 1'b0, "s4_lsl_7d_5");
    run_op(1, 1, 8'h7D, 12, 8'h00, 0, 3, 1'b1, "s4_lsr_7d_12");

    for (int i = 0; i < 60; i++) begin
      int md;
      int d;
      int amt;
      md  = $urandom_range(0, 7);
      d   = $urandom_range(0, 255);
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
      run_model(i % 2, md, d, amt, 1'($urandom), (i % 2 == 0) ? "rand_s1" : "rand_s4");
    end

    // Reset during the second cycle of a 5-position shift.
    @(negedge clk);
    start_v[0] = 1'b1; mode_v[0] = 3'b000; data_v[0] = 8'h7D; amt_v[0] = 8'd5;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    check_eq("abort_busy", int'(busy_v[0]), 0);
    check_eq("abort_done", int'(done_v[0]), 0);
    check_eq("abort_result", int'(res_v[0]), 0);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) dones++;
    end
    check_eq("abort_no_done", dones, 0);

    run_op(0, 4, 8'h01, 3, 8'h20, 0, 4, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
